// File: rtl/moesif_snoop_controller_if.sv
// Bus and snoop-port signal bundle for the MOESIF snoop controller.
// The slave modport is the controller view. The master modport is the
// bus/cache view.
interface moesif_snoop_controller_if #(
    parameter int TAG_WIDTH    = 8,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int ID_WIDTH     = 2
);
    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    logic                    busRequest;
    logic [1:0]              busCommand;
    logic [ID_WIDTH-1:0]     busRequesterId;
    logic [ADDR_WIDTH-1:0]   busAddress;
    logic                    busAck;
    logic                    sharedOut;
    logic                    supplyOut;
    logic [DATA_WIDTH-1:0]   busDataOut;
    logic [TAG_WIDTH-1:0]    snoopTag;
    logic [INDEX_WIDTH-1:0]  snoopIndex;
    logic [OFFSET_WIDTH-1:0] snoopOffset;
    logic                    snoopHit;
    logic [2:0]              snoopStateOut;
    logic [DATA_WIDTH-1:0]   snoopDataOut;
    logic                    snoopWriteState;
    logic [2:0]              snoopStateIn;
    logic                    cacheBusy;
    logic                    invalidateEnable;

    modport slave (
        input  busRequest, busCommand, busRequesterId, busAddress,
               snoopHit, snoopStateOut, snoopDataOut, cacheBusy,
        output busAck, sharedOut, supplyOut, busDataOut,
               snoopTag, snoopIndex, snoopOffset,
               snoopWriteState, snoopStateIn, invalidateEnable
    );

    modport master (
        output busRequest, busCommand, busRequesterId, busAddress,
               snoopHit, snoopStateOut, snoopDataOut, cacheBusy,
        input  busAck, sharedOut, supplyOut, busDataOut,
               snoopTag, snoopIndex, snoopOffset,
               snoopWriteState, snoopStateIn, invalidateEnable
    );
endinterface

// File: rtl/moesif_snoop_controller.sv
// MOESIF snoop controller: watches word-by-word bus transactions from other
// caches. It looks the word up in the local snoop port, and it reports
// shared/supply with data. On the last word of a read block, or on an
// invalidate, it rewrites the local line state.
module moesif_snoop_controller #(
    parameter int TAG_WIDTH    = 8,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int ID_WIDTH     = 2,
    parameter int CACHE_ID     = 0
) (
    input logic                      clock,
    input logic                      reset,
    moesif_snoop_controller_if.slave bus
);
    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_RDX   = 2'd1;
    localparam logic [1:0] CMD_INVAL = 2'd2;

    localparam logic [2:0] S_INVALID   = 3'd0;
    localparam logic [2:0] S_SHARED    = 3'd1;
    localparam logic [2:0] S_EXCLUSIVE = 3'd2;
    localparam logic [2:0] S_OWNED     = 3'd3;
    localparam logic [2:0] S_MODIFIED  = 3'd4;
    localparam logic [2:0] S_FORWARD   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_RESPOND = 2'd2,
        ST_UPDATE  = 2'd3
    } fsm_t;

    fsm_t                    fsm_r;
    logic [1:0]              cmd_r;
    logic                    ack_r;
    logic                    ack_last_r;
    logic                    shared_r;
    logic                    supply_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [TAG_WIDTH-1:0]    tag_r;
    logic [INDEX_WIDTH-1:0]  index_r;
    logic [OFFSET_WIDTH-1:0] offset_r;
    logic                    write_r;
    logic [2:0]              state_in_r;
    logic                    inval_r;
    logic                    due_r;
    logic [2:0]              new_state_r;

    logic                    own_s;
    logic                    accept_s;
    logic                    owner_s;
    logic                    supply_s;
    logic                    change_s;
    logic                    due_s;
    logic [2:0]              new_state_s;

    assign bus.busAck           = ack_r;
    assign bus.sharedOut        = shared_r;
    assign bus.supplyOut        = supply_r;
    assign bus.busDataOut       = data_r;
    assign bus.snoopTag         = tag_r;
    assign bus.snoopIndex       = index_r;
    assign bus.snoopOffset      = offset_r;
    assign bus.snoopWriteState  = write_r;
    assign bus.snoopStateIn     = state_in_r;
    assign bus.invalidateEnable = inval_r;

    // Decode request acceptance, supply condition and next line state.
    always_comb begin
        own_s       = (bus.busRequesterId == ID_WIDTH'(CACHE_ID));
        // A request still held high right after its ack is not a new one.
        accept_s    = bus.busRequest && !ack_r && !ack_last_r;
        owner_s     = (bus.snoopStateOut == S_MODIFIED) || (bus.snoopStateOut == S_OWNED) ||
                      (bus.snoopStateOut == S_EXCLUSIVE) || (bus.snoopStateOut == S_FORWARD);
        supply_s    = bus.snoopHit && owner_s && ((cmd_r == CMD_READ) || (cmd_r == CMD_RDX));
        change_s    = 1'b0;
        new_state_s = bus.snoopStateOut;
        case (cmd_r)
            CMD_READ: begin
                case (bus.snoopStateOut)
                    S_MODIFIED:  begin change_s = 1'b1; new_state_s = S_OWNED;  end
                    S_EXCLUSIVE: begin change_s = 1'b1; new_state_s = S_SHARED; end
                    S_FORWARD:   begin change_s = 1'b1; new_state_s = S_SHARED; end
                    default:     begin change_s = 1'b0; new_state_s = bus.snoopStateOut; end
                endcase
            end
            CMD_RDX, CMD_INVAL: begin
                change_s    = 1'b1;
                new_state_s = S_INVALID;
            end
            default: begin
                change_s    = 1'b0;
                new_state_s = bus.snoopStateOut;
            end
        endcase
        // Reads change the state only on the last word, so earlier words still see the old owner.
        if (cmd_r == CMD_INVAL) begin
            due_s = bus.snoopHit && change_s;
        end else begin
            due_s = bus.snoopHit && change_s && (&offset_r);
        end
    end

    // Snoop FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_r       <= ST_IDLE;
            cmd_r       <= 2'd0;
            ack_r       <= 1'b0;
            ack_last_r  <= 1'b0;
            shared_r    <= 1'b0;
            supply_r    <= 1'b0;
            data_r      <= '0;
            tag_r       <= '0;
            index_r     <= '0;
            offset_r    <= '0;
            write_r     <= 1'b0;
            state_in_r  <= 3'd0;
            inval_r     <= 1'b0;
            due_r       <= 1'b0;
            new_state_r <= 3'd0;
        end else begin
            ack_last_r <= ack_r;
            case (fsm_r)
                ST_IDLE: begin
                    ack_r    <= 1'b0;
                    shared_r <= 1'b0;
                    supply_r <= 1'b0;
                    data_r   <= '0;
                    write_r  <= 1'b0;
                    inval_r  <= 1'b0;
                    if (accept_s && own_s) begin
                        ack_r <= 1'b1;
                    end else if (accept_s) begin
                        cmd_r    <= bus.busCommand;
                        {tag_r, index_r, offset_r} <= bus.busAddress;
                        fsm_r    <= ST_LOOKUP;
                    end else begin
                        fsm_r <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    if (!bus.cacheBusy) begin
                        ack_r       <= 1'b1;
                        shared_r    <= bus.snoopHit;
                        supply_r    <= supply_s;
                        data_r      <= supply_s ? bus.snoopDataOut : '0;
                        due_r       <= due_s;
                        new_state_r <= new_state_s;
                        fsm_r       <= ST_RESPOND;
                    end else begin
                        fsm_r <= ST_LOOKUP;
                    end
                end
                ST_RESPOND: begin
                    ack_r <= 1'b0;
                    if (due_r) begin
                        write_r    <= 1'b1;
                        state_in_r <= new_state_r;
                        inval_r    <= (new_state_r == S_INVALID);
                        fsm_r      <= ST_UPDATE;
                    end else begin
                        shared_r <= 1'b0;
                        supply_r <= 1'b0;
                        data_r   <= '0;
                        fsm_r    <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    write_r  <= 1'b0;
                    inval_r  <= 1'b0;
                    shared_r <= 1'b0;
                    supply_r <= 1'b0;
                    data_r   <= '0;
                    fsm_r    <= ST_IDLE;
                end
                default: begin
                    ack_r    <= 1'b0;
                    write_r  <= 1'b0;
                    inval_r  <= 1'b0;
                    shared_r <= 1'b0;
                    supply_r <= 1'b0;
                    data_r   <= '0;
                    fsm_r    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
